// File: rtl/sd_dat_rx_if.sv
// Bus bundle for the SD DAT0 receive path: bit strobe/line in, byte stream and status out.
interface sd_dat_rx_if;
  logic        start;
  logic        bit_en;
  logic        dat_in;
  logic [7:0]  data_out;
  logic        data_valid;
  logic        busy;
  logic        done;
  logic        crc_ok;
  logic        crc_err;
  logic        timeout;
  logic [15:0] rx_crc;
  logic [15:0] calc_crc;

  modport master (
    output start, bit_en, dat_in,
    input  data_out, data_valid, busy, done, crc_ok, crc_err, timeout, rx_crc, calc_crc
  );

  modport slave (
    input  start, bit_en, dat_in,
    output data_out, data_valid, busy, done, crc_ok, crc_err, timeout, rx_crc, calc_crc
  );
endinterface

// File: rtl/sd_dat_rx.sv
// SD DAT0 block receiver: start-bit hunt, MSB-first byte deserialiser, CRC16-CCITT check, end bit.
module sd_dat_rx #(
  parameter int BLOCK_LEN = 512,
  parameter int TIMEOUT   = 65535
) (
  input logic        clk,
  input logic        rst,
  sd_dat_rx_if.slave bus
);
  localparam int BCW = $clog2(BLOCK_LEN + 1);

  typedef enum logic [2:0] {IDLE, WAIT_START, DATA, CRC, STOP} state_t;

  state_t         r_state;
  logic [BCW-1:0] r_byte_cnt;
  logic [3:0]     r_bit_cnt;
  logic [15:0]    r_wait_cnt;
  logic [7:0]     r_shift;
  logic [7:0]     r_data_out;
  logic           r_data_valid;
  logic           r_busy;
  logic           r_done;
  logic           r_crc_ok;
  logic           r_crc_err;
  logic           r_timeout;
  logic [15:0]    r_rx_crc;
  logic [15:0]    r_calc_crc;

  logic [7:0]     w_byte;
  logic [15:0]    w_wait_nxt;
  logic           w_match;

  // Byte-parallel x^16+x^12+x^5+1, same equations as the transmit-side generator.
  function automatic logic [15:0] next_crc16_d8(input logic [7:0] d, input logic [15:0] c);
    logic [7:0] x;
    x = c[15:8] ^ d;
    x = x ^ {4'h0, x[7:4]};
    return {c[7:0], 8'h00} ^ {x[3:0], 12'h000} ^ {3'b000, x, 5'b00000} ^ {8'h00, x};
  endfunction

  assign w_byte     = {r_shift[6:0], bus.dat_in};
  assign w_wait_nxt = r_wait_cnt + 16'd1;
  assign w_match    = (r_rx_crc == r_calc_crc);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= IDLE;
      r_byte_cnt   <= '0;
      r_bit_cnt    <= '0;
      r_wait_cnt   <= '0;
      r_shift      <= '0;
      r_data_out   <= '0;
      r_data_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_crc_ok     <= 1'b0;
      r_crc_err    <= 1'b0;
      r_timeout    <= 1'b0;
      r_rx_crc     <= '0;
      r_calc_crc   <= '0;
    end else begin
      r_data_valid <= 1'b0;
      r_done       <= 1'b0;
      case (r_state)
        IDLE: if (bus.start) begin
          r_state    <= WAIT_START;
          r_busy     <= 1'b1;
          r_crc_ok   <= 1'b0;
          r_crc_err  <= 1'b0;
          r_timeout  <= 1'b0;
          r_calc_crc <= '0;
          r_rx_crc   <= '0;
          r_wait_cnt <= '0;
        end
        WAIT_START: if (bus.bit_en) begin
          if (!bus.dat_in) begin
            r_state    <= DATA;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end else begin
            r_wait_cnt <= w_wait_nxt;
            if (w_wait_nxt == 16'(TIMEOUT)) begin
              r_state   <= IDLE;
              r_timeout <= 1'b1;
              r_busy    <= 1'b0;
            end
          end
        end
        DATA: if (bus.bit_en) begin
          r_shift   <= w_byte;
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd7) begin
            r_bit_cnt    <= '0;
            r_data_out   <= w_byte;
            r_data_valid <= 1'b1;
            r_calc_crc   <= next_crc16_d8(w_byte, r_calc_crc);
            r_byte_cnt   <= r_byte_cnt + 1'b1;
            if (r_byte_cnt == BCW'(BLOCK_LEN - 1)) r_state <= CRC;
          end
        end
        CRC: if (bus.bit_en) begin
          r_rx_crc  <= {r_rx_crc[14:0], bus.dat_in};
          r_bit_cnt <= r_bit_cnt + 4'd1;
          if (r_bit_cnt == 4'd15) begin
            r_bit_cnt <= '0;
            r_state   <= STOP;
          end
        end
        STOP: if (bus.bit_en) begin
          r_crc_ok  <= w_match && bus.dat_in;
          r_crc_err <= !(w_match && bus.dat_in);
          r_done    <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.data_out   = r_data_out;
  assign bus.data_valid = r_data_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
  assign bus.crc_ok     = r_crc_ok;
  assign bus.crc_err    = r_crc_err;
  assign bus.timeout    = r_timeout;
  assign bus.rx_crc     = r_rx_crc;
  assign bus.calc_crc   = r_calc_crc;
endmodule

// File: tb/tb_sd_dat_rx.sv
// Scoreboard bench for sd_dat_rx: a 512-byte instance and a 4-byte/TIMEOUT=10 instance share the bit line.
`timescale 1ns/1ps
module tb_sd_dat_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start_b = 1'b0, start_s = 1'b0, bit_en = 1'b0, dat_in = 1'b1;
  always #5 clk = ~clk;

  sd_dat_rx_if if_b();
  sd_dat_rx_if if_s();
  assign if_b.start = start_b;  assign if_b.bit_en = bit_en;  assign if_b.dat_in = dat_in;
  assign if_s.start = start_s;  assign if_s.bit_en = bit_en;  assign if_s.dat_in = dat_in;

  sd_dat_rx #(.BLOCK_LEN(512), .TIMEOUT(65535)) u_b (.clk(clk), .rst(rst), .bus(if_b));
  sd_dat_rx #(.BLOCK_LEN(4),   .TIMEOUT(10))    u_s (.clk(clk), .rst(rst), .bus(if_s));

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  int dv_b = 0, dv_s = 0, dn_b = 0, dn_s = 0, last_s = -1;
  bit gap_chk = 1'b0;
  logic [7:0] q_b[$], q_s[$], pl[$];

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h want 0x%0h", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Scoreboard: every data_valid pops the oldest byte driven onto the line.
  always @(negedge clk) begin
    if (if_b.data_valid) begin
      dv_b++;
      chk("b_q_nonempty", 32'(q_b.size() != 0), 1);
      if (q_b.size() != 0) chk("b_data", if_b.data_out, q_b.pop_front());
    end
    if (if_b.done) dn_b++;
    if (if_s.data_valid) begin
      dv_s++;
      chk("s_q_nonempty", 32'(q_s.size() != 0), 1);
      if (q_s.size() != 0) chk("s_data", if_s.data_out, q_s.pop_front());
      if (gap_chk && last_s >= 0) chk("s_dv_gap", 32'(cyc - last_s), 8);
      last_s = cyc;
    end
    if (if_s.done) dn_s++;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic set_start(input bit sel, input logic v);
    if (sel) start_s = v; else start_b = v;
  endtask

  task automatic send_bit(input logic b, input int gap);
    dat_in = b; bit_en = 1'b1;
    step(1);
    bit_en = 1'b0; dat_in = 1'b1;
    if (gap > 0) step(gap);
  endtask

  function automatic logic [15:0] crc_ref();
    logic [15:0] c;
    logic [7:0]  b;
    logic        fb;
    c = '0;
    foreach (pl[i]) begin
      b = pl[i];
      for (int k = 7; k >= 0; k--) begin
        fb = c[15] ^ b[k];
        c  = {c[14:0], 1'b0};
        if (fb) c = c ^ 16'h1021;
      end
    end
    return c;
  endfunction

  task automatic send_frame(input bit sel, input int nlead, input logic [15:0] crc, input logic endb,
                            input int gap, input int rst_at, input int kick_at, input bit start_on_end);
    logic [7:0] b;
    set_start(sel, 1'b1); step(1); set_start(sel, 1'b0);
    repeat (nlead) send_bit(1'b1, gap);
    send_bit(1'b0, gap);
    foreach (pl[i]) begin
      if (i == rst_at) begin
        rst = 1'b1; step(1); rst = 1'b0;
        return;
      end
      b = pl[i];
      if (sel) q_s.push_back(b); else q_b.push_back(b);
      for (int k = 7; k >= 0; k--) begin
        if (i == kick_at && k == 7) set_start(sel, 1'b1);
        send_bit(b[k], gap);
        set_start(sel, 1'b0);
      end
    end
    for (int k = 15; k >= 0; k--) send_bit(crc[k], gap);
    dat_in = endb; bit_en = 1'b1;
    if (start_on_end) set_start(sel, 1'b1);
    step(1);
    bit_en = 1'b0; dat_in = 1'b1; set_start(sel, 1'b0);
  endtask

  task automatic check_idle_b(input string t);
    chk({t, "_data_out"}, if_b.data_out, 0);
    chk({t, "_dv"},       if_b.data_valid, 0);
    chk({t, "_busy"},     if_b.busy, 0);
    chk({t, "_done"},     if_b.done, 0);
    chk({t, "_ok"},       if_b.crc_ok, 0);
    chk({t, "_err"},      if_b.crc_err, 0);
    chk({t, "_tmo"},      if_b.timeout, 0);
    chk({t, "_rx_crc"},   if_b.rx_crc, 0);
    chk({t, "_calc_crc"}, if_b.calc_crc, 0);
  endtask

  // Called right after the end-bit strobe edge: done must be up now and gone one clk later.
  task automatic check_end_b(input string t, input logic ok, input logic err,
                             input logic [15:0] rx, input logic [15:0] calc, input int dv0, input int dn0);
    chk({t, "_done"}, if_b.done, 1);
    chk({t, "_busy"}, if_b.busy, 0);
    chk({t, "_ok"},   if_b.crc_ok, ok);
    chk({t, "_err"},  if_b.crc_err, err);
    chk({t, "_rx"},   if_b.rx_crc, rx);
    chk({t, "_calc"}, if_b.calc_crc, calc);
    step(2);
    chk({t, "_done_pulse"}, if_b.done, 0);
    chk({t, "_ok_hold"},    if_b.crc_ok, ok);
    chk({t, "_dn_cnt"},     32'(dn_b - dn0), 1);
    chk({t, "_dv_cnt"},     32'(dv_b - dv0), 512);
    chk({t, "_q_empty"},    32'(q_b.size()), 0);
  endtask

  initial begin
    int dv0, dn0;
    logic [15:0] gold;
    step(2);
    check_idle_b("rst");
    chk("rst_s_busy", if_s.busy, 0);
    chk("rst_s_tmo",  if_s.timeout, 0);
    rst = 1'b0;
    step(2);

    pl.delete();
    repeat (512) pl.push_back(8'hFF);

    dv0 = dv_b; dn0 = dn_b;
    send_frame(1'b0, 3, 16'h7FA1, 1'b1, 0, -1, -1, 1'b0);
    check_end_b("ff_good", 1'b1, 1'b0, 16'h7FA1, 16'h7FA1, dv0, dn0);

    dv0 = dv_b; dn0 = dn_b;
    send_frame(1'b0, 3, 16'h7FA0, 1'b1, 0, -1, -1, 1'b0);
    check_end_b("ff_badcrc", 1'b0, 1'b1, 16'h7FA0, 16'h7FA1, dv0, dn0);

    // Start on the done cycle must be ignored: busy stays low and the error flag survives.
    dv0 = dv_b; dn0 = dn_b;
    send_frame(1'b0, 0, 16'h7FA1, 1'b0, 0, -1, -1, 1'b1);
    check_end_b("ff_endbit0", 1'b0, 1'b1, 16'h7FA1, 16'h7FA1, dv0, dn0);
    chk("start_on_done_busy", if_b.busy, 0);
    chk("start_on_done_err",  if_b.crc_err, 1);

    dv0 = dv_b; dn0 = dn_b;
    send_frame(1'b0, 1, 16'h7FA1, 1'b1, 0, 100, -1, 1'b0);
    check_idle_b("midrst");
    chk("midrst_dv_cnt", 32'(dv_b - dv0), 100);
    step(3);
    chk("midrst_no_done", 32'(dn_b - dn0), 0);

    dv0 = dv_b; dn0 = dn_b;
    send_frame(1'b0, 2, 16'h7FA1, 1'b1, 0, -1, 50, 1'b0);
    check_end_b("kick_busy", 1'b1, 1'b0, 16'h7FA1, 16'h7FA1, dv0, dn0);

    dv0 = dv_s; dn0 = dn_s;
    start_s = 1'b1; step(1); start_s = 1'b0;
    chk("tmo_busy_armed", if_s.busy, 1);
    repeat (9) send_bit(1'b1, 1);
    chk("tmo_9_flag", if_s.timeout, 0);
    chk("tmo_9_busy", if_s.busy, 1);
    send_bit(1'b1, 0);
    chk("tmo_10_flag", if_s.timeout, 1);
    chk("tmo_10_busy", if_s.busy, 0);
    step(3);
    chk("tmo_no_done", 32'(dn_s - dn0), 0);
    chk("tmo_no_dv",   32'(dv_s - dv0), 0);
    chk("tmo_hold",    if_s.timeout, 1);

    pl.delete();
    pl.push_back(8'h01); pl.push_back(8'h02); pl.push_back(8'h03); pl.push_back(8'h04);
    gold = crc_ref();
    for (int pass = 0; pass < 2; pass++) begin
      gap_chk = (pass == 1);
      last_s  = -1;
      dv0 = dv_s; dn0 = dn_s;
      send_frame(1'b1, 3, gold, 1'b1, (pass == 0) ? 2 : 0, -1, -1, 1'b0);
      chk("s4_done",     if_s.done, 1);
      chk("s4_ok",       if_s.crc_ok, 1);
      chk("s4_err",      if_s.crc_err, 0);
      chk("s4_tmo_clr",  if_s.timeout, 0);
      chk("s4_calc",     if_s.calc_crc, gold);
      chk("s4_rx",       if_s.rx_crc, gold);
      step(2);
      chk("s4_dv_cnt",   32'(dv_s - dv0), 4);
      chk("s4_dn_cnt",   32'(dn_s - dn0), 1);
      chk("s4_q_empty",  32'(q_s.size()), 0);
    end
    gap_chk = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
